// File: rtl/count_timer.sv
// Up/down counter-timer with wrap, saturate and one-shot modes, compare match and sticky irq.
// Optional prescaler enabled by defining COUNT_PRESCALE_EN.
module count_timer #(
    parameter int WIDTH      = 12,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  dir_i,
    input  logic [1:0]            mode_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic [WIDTH-1:0]      cmp_i,
`ifdef COUNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_i,
`endif
    input  logic                  irq_clr_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  match_o,
    output logic                  wrap_o,
    output logic                  done_o,
    output logic                  irq_o
);

    typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

    if (WIDTH < 2 || WIDTH > 32 || PRESCALE_W < 1) begin : g_bad_param
        $error("count_timer: illegal WIDTH or PRESCALE_W");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             match_q, match_d;
    logic             wrap_q, wrap_d;
    logic             irq_q, irq_d;
    logic             tick_s;
    logic             at_bound_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] wrap_val_s;

`ifdef COUNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    // Prescaler: a load restarts the period; otherwise it advances on each enabled cycle.
    always_comb begin
        presc_d = presc_q;
        tick_s  = 1'b0;
        if (load_i) begin
            presc_d = '0;
        end else if (en_i) begin
            if (presc_q == prescale_i) begin
                presc_d = '0;
                tick_s  = 1'b1;
            end else begin
                presc_d = presc_q + PRESCALE_W'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick_s = en_i;
`endif

    assign at_bound_s = dir_i ? (&count_q) : ~(|count_q);
    assign step_s     = dir_i ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    assign wrap_val_s = dir_i ? '0 : '1;

    // Next-state: load beats tick beats hold; match only on a tick that changed the count.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        match_d = 1'b0;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
            state_d = RUN;
        end else if (tick_s && (state_q == RUN)) begin
            if (!at_bound_s) begin
                count_d = step_s;
                match_d = (step_s == cmp_i);
            end else begin
                case (mode_i)
                    2'b01: begin
                        count_d = count_q;
                    end
                    2'b10: begin
                        state_d = DONE;
                        wrap_d  = 1'b1;
                    end
                    default: begin
                        count_d = wrap_val_s;
                        wrap_d  = 1'b1;
                        match_d = (wrap_val_s == cmp_i);
                    end
                endcase
            end
        end else begin
            count_d = count_q;
        end
    end

    // Sticky interrupt: a pending match/wrap pulse beats a simultaneous clear.
    always_comb begin
        if (match_q || wrap_q) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            count_q <= '0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
            irq_q   <= irq_d;
        end
    end

    assign count_o = count_q;
    assign match_o = match_q;
    assign wrap_o  = wrap_q;
    assign done_o  = (state_q == DONE);
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_count_timer.sv
// Directed, table-driven bench for count_timer at WIDTH=4.
module tb_count_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, dir, load, irq_clr;
    logic [1:0]   mode;
    logic [W-1:0] load_val, cmp;
    logic [W-1:0] count;
    logic         match, wrap, done, irq;
`ifdef COUNT_PRESCALE_EN
    logic [7:0]   prescale;
`endif

    int errors = 0;
    int checks = 0;

    count_timer #(.WIDTH(W), .PRESCALE_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .dir_i      (dir),
        .mode_i     (mode),
        .load_i     (load),
        .load_val_i (load_val),
        .cmp_i      (cmp),
`ifdef COUNT_PRESCALE_EN
        .prescale_i (prescale),
`endif
        .irq_clr_i  (irq_clr),
        .count_o    (count),
        .match_o    (match),
        .wrap_o     (wrap),
        .done_o     (done),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         e;
        logic         d;
        logic [1:0]   m;
        logic [W-1:0] c;
        logic         clr;
        logic [W-1:0] x_cnt;
        logic         x_match;
        logic         x_wrap;
        logic         x_done;
        logic         x_irq;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] c, input logic m,
                             input logic w, input logic d, input logic i);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".match"}, 32'(match), 32'(m));
        check({tag, ".wrap"},  32'(wrap),  32'(w));
        check({tag, ".done"},  32'(done),  32'(d));
        check({tag, ".irq"},   32'(irq),   32'(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic e,
                                input logic d, input logic [1:0] m, input logic [W-1:0] c,
                                input logic clr, input logic [W-1:0] xc, input logic xm,
                                input logic xw, input logic xd, input logic xi);
        vec_t v;
        v.ld = ld; v.lv = lv; v.e = e; v.d = d; v.m = m; v.c = c; v.clr = clr;
        v.x_cnt = xc; v.x_match = xm; v.x_wrap = xw; v.x_done = xd; v.x_irq = xi;
        return v;
    endfunction

    initial begin
        // ld lv e d mode cmp clr | count match wrap done irq
        vecs[0]  = mk(1'b1, 4'd3,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1);
        vecs[6]  = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b00, 4'hF, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1);
        vecs[7]  = mk(1'b1, 4'd5,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b10, 4'hF, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 4'd0,  1'b0, 1'b0, 2'b10, 4'hF, 1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 4'd14, 1'b1, 1'b1, 2'b01, 4'hF, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 4'd0,  1'b1, 1'b1, 2'b01, 4'hF, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 4'd0,  1'b1, 1'b1, 2'b01, 4'hF, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 4'd0,  1'b1, 1'b1, 2'b01, 4'hF, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b1, 4'd1,  1'b1, 1'b0, 2'b11, 4'hF, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b11, 4'hF, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 4'd0,  1'b1, 1'b0, 2'b11, 4'hF, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 4'd0,  1'b0, 1'b0, 2'b11, 4'hF, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[18] = mk(1'b1, 4'd15, 1'b0, 1'b0, 2'b11, 4'hF, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 4'd0,  1'b1, 1'b1, 2'b00, 4'hF, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0);

        rst = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'b00; load = 1'b0; irq_clr = 1'b0;
        load_val = 4'd0; cmp = 4'd5;
`ifdef COUNT_PRESCALE_EN
        prescale = 8'd0;
`endif
        #12;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Free-running wrap-up from reset with cmp=5.
        en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check_all($sformatf("wrap_up[%0d]", k), W'(k % 16), (k == 5), (k == 16),
                      1'b0, (k >= 6));
        end
        en = 1'b0; irq_clr = 1'b1;
        step();
        check("wrap_up.irq_clr", 32'(irq), 32'd0);
        irq_clr = 1'b0;

        for (int i = 0; i < NV; i++) begin
            load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].e; dir = vecs[i].d;
            mode = vecs[i].m; cmp = vecs[i].c; irq_clr = vecs[i].clr;
            step();
            check_all($sformatf("vec[%0d]", i), vecs[i].x_cnt, vecs[i].x_match,
                      vecs[i].x_wrap, vecs[i].x_done, vecs[i].x_irq);
            if (i == 13) begin
                irq_clr = 1'b0;
                for (int h = 0; h < 10; h++) begin
                    step();
                    check_all($sformatf("sat_hold[%0d]", h), 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
        end

        // Asynchronous reset mid-count at 9.
        load = 1'b1; load_val = 4'd8; en = 1'b1; dir = 1'b1; mode = 2'b00; cmp = 4'h0;
        irq_clr = 1'b0;
        step();
        load = 1'b0;
        step();
        check("pre_rst.count", 32'(count), 32'd9);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst.count", 32'(count), 32'd1);

`ifdef COUNT_PRESCALE_EN
        prescale = 8'd2; load = 1'b1; load_val = 4'd0; en = 1'b1;
        step();
        load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("presc[%0d]", k), 32'(count), 32'(k / 3));
        end
        step();
        load = 1'b1; load_val = 4'd7;
        step();
        load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("presc_ld[%0d]", k), 32'(count), (k == 3) ? 32'd8 : 32'd7);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
